// File: rtl/rename_pkg.sv
// Shared types and sizing for the checkpointed rename map.
// Pure declarations plus small combinational helpers; no state.
package rename_pkg;
  localparam int ARCH_REGS = 32;
  localparam int PREG_NUM  = 64;
  localparam int W         = 2;
  localparam int CDB_SIZE  = 2;
  localparam int CKPT_NUM  = 4;
  localparam int AW        = $clog2(ARCH_REGS);
  localparam int PW        = $clog2(PREG_NUM);
  localparam int CW        = $clog2(CKPT_NUM);
  localparam int SW        = (W > 1) ? $clog2(W) : 1;

  typedef logic [AW-1:0] areg_t;
  typedef logic [PW-1:0] preg_t;
  typedef logic [CW-1:0] ckpt_id_t;
  typedef logic [CW:0]   ckpt_cnt_t;

  localparam areg_t ZERO_REG = '0;

  typedef struct packed {
    preg_t [ARCH_REGS-1:0] map;
    logic  [ARCH_REGS-1:0] ready;
  } map_state_t;

  function automatic map_state_t reset_map();
    map_state_t s;
    for (int i = 0; i < ARCH_REGS; i++) s.map[i] = preg_t'(i);
    s.ready = '1;
    return s;
  endfunction

  function automatic logic cdb_hit(preg_t tag, preg_t [CDB_SIZE-1:0] cdb_ptag,
                                   logic [CDB_SIZE-1:0] cdb_valid);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < CDB_SIZE; c++) hit = hit | (cdb_valid[c] && cdb_ptag[c] == tag);
    return hit;
  endfunction

  function automatic map_state_t apply_cdb(map_state_t s, preg_t [CDB_SIZE-1:0] cdb_ptag,
                                           logic [CDB_SIZE-1:0] cdb_valid);
    map_state_t r;
    r = s;
    for (int i = 0; i < ARCH_REGS; i++) r.ready[i] = s.ready[i] | cdb_hit(s.map[i], cdb_ptag, cdb_valid);
    return r;
  endfunction
endpackage

// File: rtl/rename_map_ckpt_if.sv
// Dispatch-side bundle of the rename map: decode/free-list inputs, RS/ROB outputs, CDB and recovery.
// Master drives the group and recovery controls; slave is the map table.
interface rename_map_ckpt_if;
  import rename_pkg::*;

  logic                         rename_en_i;
  areg_t    [2*W-1:0]           src_areg_i;
  areg_t    [W-1:0]             dst_areg_i;
  logic     [W-1:0]             dst_valid_i;
  preg_t    [W-1:0]             new_ptag_i;
  preg_t    [2*W-1:0]           src_ptag_o;
  logic     [2*W-1:0]           src_ready_o;
  preg_t    [W-1:0]             old_ptag_o;
  logic                         ckpt_req_i;
  logic     [SW-1:0]            ckpt_slot_i;
  ckpt_id_t                     ckpt_id_o;
  logic                         ckpt_full_o;
  logic                         ckpt_release_i;
  preg_t    [CDB_SIZE-1:0]      cdb_ptag_i;
  logic     [CDB_SIZE-1:0]      cdb_valid_i;
  logic                         recover_ckpt_i;
  ckpt_id_t                     recover_ckpt_id_i;
  logic                         recover_arch_i;
  preg_t    [ARCH_REGS-1:0]     arch_table_i;

  modport master (
    output rename_en_i, src_areg_i, dst_areg_i, dst_valid_i, new_ptag_i,
    output ckpt_req_i, ckpt_slot_i, ckpt_release_i, cdb_ptag_i, cdb_valid_i,
    output recover_ckpt_i, recover_ckpt_id_i, recover_arch_i, arch_table_i,
    input  src_ptag_o, src_ready_o, old_ptag_o, ckpt_id_o, ckpt_full_o
  );

  modport slave (
    input  rename_en_i, src_areg_i, dst_areg_i, dst_valid_i, new_ptag_i,
    input  ckpt_req_i, ckpt_slot_i, ckpt_release_i, cdb_ptag_i, cdb_valid_i,
    input  recover_ckpt_i, recover_ckpt_id_i, recover_arch_i, arch_table_i,
    output src_ptag_o, src_ready_o, old_ptag_o, ckpt_id_o, ckpt_full_o
  );
endinterface

// File: rtl/rename_ckpt_store.sv
// Circular checkpoint store: snapshots written at tail, released at head, CDB keeps stored ready bits live.
// Read of a checkpoint is combinational; pointer/storage updates land on the next edge; full is registered count.
module rename_ckpt_store
  import rename_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  preg_t [CDB_SIZE-1:0]    cdb_ptag_i,
  input  logic  [CDB_SIZE-1:0]    cdb_valid_i,
  input  logic                    alloc_i,
  input  map_state_t              alloc_state_i,
  input  logic                    release_i,
  input  logic                    recover_ckpt_i,
  input  ckpt_id_t                recover_id_i,
  input  logic                    recover_arch_i,
  output map_state_t              rd_state_o,
  output ckpt_id_t                tail_o,
  output logic                    full_o
);
  map_state_t ckpt_q [CKPT_NUM];
  map_state_t ckpt_d [CKPT_NUM];
  ckpt_id_t   head_q, head_d, tail_q, tail_d;
  ckpt_cnt_t  count_q, count_d;
  logic       alloc_ok, release_ok;

  assign full_o     = (count_q == ckpt_cnt_t'(CKPT_NUM));
  assign tail_o     = tail_q;
  assign release_ok = release_i && (count_q != '0);
  // A release frees the head slot in the same cycle, so a full store may still accept an allocation.
  assign alloc_ok   = alloc_i && (!full_o || release_ok);
  assign rd_state_o = apply_cdb(ckpt_q[recover_id_i], cdb_ptag_i, cdb_valid_i);

  always_comb begin
    for (int e = 0; e < CKPT_NUM; e++) ckpt_d[e] = apply_cdb(ckpt_q[e], cdb_ptag_i, cdb_valid_i);
    if (alloc_ok) ckpt_d[tail_q] = alloc_state_i;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (recover_arch_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (recover_ckpt_i) begin
      head_d  = head_q + ckpt_id_t'(release_ok);
      tail_d  = recover_id_i;
      count_d = {1'b0, ckpt_id_t'(recover_id_i - head_d)};
    end else begin
      head_d  = head_q + ckpt_id_t'(release_ok);
      tail_d  = tail_q + ckpt_id_t'(alloc_ok);
      count_d = count_q + ckpt_cnt_t'(alloc_ok) - ckpt_cnt_t'(release_ok);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < CKPT_NUM; e++) ckpt_q[e] <= reset_map();
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int e = 0; e < CKPT_NUM; e++) ckpt_q[e] <= ckpt_d[e];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  a_no_alloc_when_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(alloc_i && full_o && !release_i));
  a_no_release_when_empty: assert property (@(posedge clk) disable iff (!reset_n)
    !(release_i && count_q == '0));
endmodule

// File: rtl/rename_map_ckpt.sv
// W-wide rename map with intra-group forwarding, CDB ready tracking and per-branch checkpoints.
// Lookup is combinational, state updates next edge; no internal backpressure, upstream stalls on ckpt_full_o.
module rename_map_ckpt
  import rename_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  rename_map_ckpt_if.slave rif
);
  map_state_t          state_q, state_d;
  map_state_t          cdb_state, cur_state, snap_state, ckpt_rd;
  preg_t [2*W-1:0]     src_ptag;
  logic  [2*W-1:0]     src_rdy;
  preg_t [W-1:0]       old_ptag;
  logic                recovering, alloc;

  assign recovering = rif.recover_arch_i | rif.recover_ckpt_i;
  assign alloc      = rif.rename_en_i & rif.ckpt_req_i & ~recovering;

  always_comb begin
    for (int s = 0; s < 2*W; s++) begin
      src_ptag[s] = state_q.map[rif.src_areg_i[s]];
      src_rdy[s]  = state_q.ready[rif.src_areg_i[s]]
                  | cdb_hit(state_q.map[rif.src_areg_i[s]], rif.cdb_ptag_i, rif.cdb_valid_i);
      // Ascending scan over older slots leaves the youngest producer in place.
      for (int j = 0; j < W; j++) begin
        if (j < s / 2 && rif.dst_valid_i[j] && rif.dst_areg_i[j] == rif.src_areg_i[s]) begin
          src_ptag[s] = rif.new_ptag_i[j];
          src_rdy[s]  = 1'b0;
        end
      end
      if (rif.src_areg_i[s] == ZERO_REG) begin
        src_ptag[s] = '0;
        src_rdy[s]  = 1'b1;
      end
    end

    for (int i = 0; i < W; i++) begin
      old_ptag[i] = state_q.map[rif.dst_areg_i[i]];
      for (int j = 0; j < W; j++) begin
        if (j < i && rif.dst_valid_i[j] && rif.dst_areg_i[j] == rif.dst_areg_i[i])
          old_ptag[i] = rif.new_ptag_i[j];
      end
    end
  end

  assign rif.src_ptag_o  = src_ptag;
  assign rif.src_ready_o = src_rdy;
  assign rif.old_ptag_o  = old_ptag;

  // CDB is folded in before the slot writes so a rename of the same entry clears the ready bit.
  always_comb begin
    cdb_state  = apply_cdb(state_q, rif.cdb_ptag_i, rif.cdb_valid_i);
    cur_state  = cdb_state;
    snap_state = cdb_state;
    for (int k = 0; k < W; k++) begin
      if (rif.dst_valid_i[k] && rif.dst_areg_i[k] != ZERO_REG) begin
        cur_state.map[rif.dst_areg_i[k]]   = rif.new_ptag_i[k];
        cur_state.ready[rif.dst_areg_i[k]] = 1'b0;
      end
      if (rif.ckpt_slot_i == SW'(k)) snap_state = cur_state;
    end
  end

  always_comb begin
    state_d = cdb_state;
    if (rif.recover_arch_i) begin
      state_d.map   = rif.arch_table_i;
      state_d.ready = '1;
    end else if (rif.recover_ckpt_i) begin
      state_d = ckpt_rd;
    end else if (rif.rename_en_i) begin
      state_d = cur_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= reset_map();
    else          state_q <= state_d;
  end

  rename_ckpt_store u_store (
    .clk            (clk),
    .reset_n        (reset_n),
    .cdb_ptag_i     (rif.cdb_ptag_i),
    .cdb_valid_i    (rif.cdb_valid_i),
    .alloc_i        (alloc),
    .alloc_state_i  (snap_state),
    .release_i      (rif.ckpt_release_i),
    .recover_ckpt_i (rif.recover_ckpt_i & ~rif.recover_arch_i),
    .recover_id_i   (rif.recover_ckpt_id_i),
    .recover_arch_i (rif.recover_arch_i),
    .rd_state_o     (ckpt_rd),
    .tail_o         (rif.ckpt_id_o),
    .full_o         (rif.ckpt_full_o)
  );
endmodule

// File: tb/tb_rename_map_ckpt.sv
// Self-checking bench for rename_map_ckpt: per-scenario tasks push expectations, drained at the negedge.
module tb_rename_map_ckpt;
  import rename_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rename_map_ckpt_if rif ();
  rename_map_ckpt dut (.clk(clk), .reset_n(reset_n), .rif(rif));

  typedef struct { int sel; logic [31:0] exp; } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  localparam int SEL_TAG = 0, SEL_RDY = 4, SEL_OLD = 8, SEL_ID = 10, SEL_FULL = 11;

  function automatic logic [31:0] observe(int sel);
    if (sel < SEL_RDY)      return 32'(rif.src_ptag_o[sel]);
    else if (sel < SEL_OLD) return 32'(rif.src_ready_o[sel-SEL_RDY]);
    else if (sel < SEL_ID)  return 32'(rif.old_ptag_o[sel-SEL_OLD]);
    else if (sel == SEL_ID) return 32'(rif.ckpt_id_o);
    else                    return 32'(rif.ckpt_full_o);
  endfunction

  function automatic string sel_name(int sel);
    if (sel < SEL_RDY)      return $sformatf("src_ptag[%0d]", sel);
    else if (sel < SEL_OLD) return $sformatf("src_ready[%0d]", sel-SEL_RDY);
    else if (sel < SEL_ID)  return $sformatf("old_ptag[%0d]", sel-SEL_OLD);
    else if (sel == SEL_ID) return "ckpt_id";
    else                    return "ckpt_full";
  endfunction

  task automatic push(int sel, int v);
    exp_t e;
    e.sel = sel;
    e.exp = 32'(v);
    sb.push_back(e);
  endtask

  task automatic src(int s, int a);
    rif.src_areg_i[s] = areg_t'(a);
  endtask

  task automatic dst(int slot, int a, int p);
    rif.dst_areg_i[slot]  = areg_t'(a);
    rif.new_ptag_i[slot]  = preg_t'(p);
    rif.dst_valid_i[slot] = 1'b1;
  endtask

  task automatic idle();
    rif.rename_en_i       = 1'b0;
    rif.src_areg_i        = '0;
    rif.dst_areg_i        = '0;
    rif.dst_valid_i       = '0;
    rif.new_ptag_i        = '0;
    rif.ckpt_req_i        = 1'b0;
    rif.ckpt_slot_i       = '0;
    rif.ckpt_release_i    = 1'b0;
    rif.cdb_ptag_i        = '0;
    rif.cdb_valid_i       = '0;
    rif.recover_ckpt_i    = 1'b0;
    rif.recover_ckpt_id_i = '0;
    rif.recover_arch_i    = 1'b0;
    for (int i = 0; i < ARCH_REGS; i++) rif.arch_table_i[i] = preg_t'(i);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] got;
    idle();
    src(0, 5); src(1, 0); src(2, 1); src(3, 31);
    rif.dst_areg_i[0] = areg_t'(2);
    rif.dst_areg_i[1] = areg_t'(9);
    push(SEL_TAG+0, 5);  push(SEL_RDY+0, 1);
    push(SEL_TAG+1, 0);  push(SEL_RDY+1, 1);
    push(SEL_TAG+2, 1);  push(SEL_TAG+3, 31);
    push(SEL_OLD+0, 2);  push(SEL_OLD+1, 9);
    push(SEL_ID, 0);     push(SEL_FULL, 0);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.sel); n_cmp++;
      if (got !== e.exp) begin
        n_err++;
        $display("FAIL test_reset %s: got %0d expected %0d", sel_name(e.sel), got, e.exp);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    exp_t e;
    logic [31:0] got;
    for (int ph = 0; ph < 3; ph++) begin
      idle();
      case (ph)
        0: begin
          rif.rename_en_i = 1'b1;
          dst(0, 3, 40); dst(1, 3, 41);
          src(0, 3); src(1, 0); src(2, 3); src(3, 4);
          push(SEL_TAG+0, 3);  push(SEL_RDY+0, 1);
          push(SEL_TAG+1, 0);  push(SEL_RDY+1, 1);
          push(SEL_TAG+2, 40); push(SEL_RDY+2, 0);
          push(SEL_TAG+3, 4);  push(SEL_RDY+3, 1);
          push(SEL_OLD+0, 3);  push(SEL_OLD+1, 40);
        end
        1: begin
          src(0, 3); src(2, 4);
          push(SEL_TAG+0, 41); push(SEL_RDY+0, 0);
          push(SEL_TAG+2, 4);  push(SEL_RDY+2, 1);
        end
        default: begin
          dst(0, 3, 50); dst(1, 3, 42);
          rif.dst_valid_i[0] = 1'b0;
          src(2, 3);
          push(SEL_TAG+2, 41); push(SEL_RDY+2, 0);
          push(SEL_OLD+0, 41); push(SEL_OLD+1, 41);
        end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = observe(e.sel); n_cmp++;
        if (got !== e.exp) begin
          n_err++;
          $display("FAIL test_forward ph%0d %s: got %0d expected %0d", ph, sel_name(e.sel), got, e.exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cdb_bypass();
    exp_t e;
    logic [31:0] got;
    for (int ph = 0; ph < 4; ph++) begin
      idle();
      case (ph)
        0: begin
          rif.rename_en_i = 1'b1;
          dst(0, 3, 40); src(0, 3);
          push(SEL_TAG+0, 41); push(SEL_RDY+0, 0); push(SEL_OLD+0, 41);
        end
        1: begin
          src(0, 3);
          rif.cdb_ptag_i[0] = preg_t'(40);
          push(SEL_TAG+0, 40); push(SEL_RDY+0, 0);
        end
        2: begin
          src(0, 3); src(2, 3);
          rif.cdb_ptag_i[1] = preg_t'(40);
          rif.cdb_valid_i   = 2'b10;
          push(SEL_TAG+0, 40); push(SEL_RDY+0, 1);
          push(SEL_TAG+2, 40); push(SEL_RDY+2, 1);
        end
        default: begin
          src(0, 3);
          push(SEL_TAG+0, 40); push(SEL_RDY+0, 1);
        end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = observe(e.sel); n_cmp++;
        if (got !== e.exp) begin
          n_err++;
          $display("FAIL test_cdb_bypass ph%0d %s: got %0d expected %0d", ph, sel_name(e.sel), got, e.exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ckpt_recover();
    exp_t e;
    logic [31:0] got;
    for (int ph = 0; ph < 5; ph++) begin
      idle();
      case (ph)
        0: begin
          rif.rename_en_i = 1'b1; rif.ckpt_req_i = 1'b1; rif.ckpt_slot_i = '0;
          dst(0, 3, 40); dst(1, 3, 41);
          push(SEL_ID, 0); push(SEL_FULL, 0);
          push(SEL_OLD+0, 40); push(SEL_OLD+1, 40);
        end
        1: begin
          rif.rename_en_i = 1'b1;
          dst(0, 6, 51); dst(1, 3, 52); src(0, 3);
          push(SEL_TAG+0, 41); push(SEL_RDY+0, 0); push(SEL_ID, 1);
        end
        2: begin
          rif.rename_en_i = 1'b1;
          dst(0, 3, 53); src(0, 6);
          push(SEL_TAG+0, 51); push(SEL_RDY+0, 0); push(SEL_ID, 1);
        end
        3: begin
          rif.recover_ckpt_i = 1'b1; rif.recover_ckpt_id_i = '0;
          rif.rename_en_i = 1'b1; dst(0, 7, 60);
          rif.cdb_ptag_i[0] = preg_t'(40); rif.cdb_valid_i = 2'b01;
        end
        default: begin
          src(0, 3); src(1, 6); src(2, 7);
          push(SEL_TAG+0, 40); push(SEL_RDY+0, 1);
          push(SEL_TAG+1, 6);  push(SEL_RDY+1, 1);
          push(SEL_TAG+2, 7);  push(SEL_RDY+2, 1);
          push(SEL_ID, 0);     push(SEL_FULL, 0);
        end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = observe(e.sel); n_cmp++;
        if (got !== e.exp) begin
          n_err++;
          $display("FAIL test_ckpt_recover ph%0d %s: got %0d expected %0d", ph, sel_name(e.sel), got, e.exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full();
    exp_t e;
    logic [31:0] got;
    for (int ph = 0; ph < 14; ph++) begin
      idle();
      if (ph < 4) begin
        rif.rename_en_i = 1'b1; rif.ckpt_req_i = 1'b1;
        push(SEL_ID, ph); push(SEL_FULL, 0);
      end else if (ph == 4) begin
        push(SEL_ID, 0); push(SEL_FULL, 1);
      end else if (ph == 5) begin
        rif.rename_en_i = 1'b1; rif.ckpt_req_i = 1'b1; rif.ckpt_release_i = 1'b1;
        push(SEL_ID, 0); push(SEL_FULL, 1);
      end else if (ph == 6) begin
        push(SEL_ID, 1); push(SEL_FULL, 1);
      end else if (ph == 7) begin
        rif.ckpt_release_i = 1'b1;
        push(SEL_FULL, 1);
      end else if (ph == 8) begin
        push(SEL_ID, 1); push(SEL_FULL, 0);
      end else if (ph == 9) begin
        rif.recover_ckpt_i = 1'b1; rif.recover_ckpt_id_i = ckpt_id_t'(3);
      end else if (ph < 13) begin
        rif.rename_en_i = 1'b1; rif.ckpt_req_i = 1'b1;
        push(SEL_ID, (ph - 7) % CKPT_NUM); push(SEL_FULL, 0);
      end else begin
        push(SEL_ID, 2); push(SEL_FULL, 1);
      end
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = observe(e.sel); n_cmp++;
        if (got !== e.exp) begin
          n_err++;
          $display("FAIL test_full ph%0d %s: got %0d expected %0d", ph, sel_name(e.sel), got, e.exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_alloc();
    exp_t e;
    logic [31:0] got;
    for (int ph = 0; ph < 3; ph++) begin
      idle();
      case (ph)
        0: begin
          rif.rename_en_i = 1'b1; rif.ckpt_release_i = 1'b1;
          dst(0, 7, 60); src(0, 7);
          push(SEL_TAG+0, 7); push(SEL_RDY+0, 1); push(SEL_FULL, 1);
        end
        1: begin
          rif.rename_en_i = 1'b1; rif.ckpt_req_i = 1'b1;
          dst(0, 7, 61); src(0, 7);
          #2 reset_n = 1'b0;
          push(SEL_TAG+0, 7); push(SEL_RDY+0, 1);
          push(SEL_ID, 0);    push(SEL_FULL, 0);
        end
        default: begin
          reset_n = 1'b1;
          src(0, 7); src(2, 3);
          push(SEL_TAG+0, 7); push(SEL_RDY+0, 1);
          push(SEL_TAG+2, 3); push(SEL_RDY+2, 1);
          push(SEL_ID, 0);    push(SEL_FULL, 0);
        end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = observe(e.sel); n_cmp++;
        if (got !== e.exp) begin
          n_err++;
          $display("FAIL test_reset_mid_alloc ph%0d %s: got %0d expected %0d", ph, sel_name(e.sel), got, e.exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_recover_arch();
    exp_t e;
    logic [31:0] got;
    for (int ph = 0; ph < 3; ph++) begin
      idle();
      case (ph)
        0: begin
          rif.rename_en_i = 1'b1;
          dst(0, 7, 60); dst(1, 1, 61);
          push(SEL_OLD+0, 7); push(SEL_OLD+1, 1);
        end
        1: begin
          rif.recover_arch_i = 1'b1;
          rif.recover_ckpt_i = 1'b1; rif.recover_ckpt_id_i = ckpt_id_t'(2);
          rif.arch_table_i[7] = preg_t'(50);
          rif.arch_table_i[1] = preg_t'(33);
          rif.rename_en_i = 1'b1; rif.ckpt_req_i = 1'b1;
          dst(0, 7, 62);
        end
        default: begin
          src(0, 7); src(1, 1); src(2, 2);
          push(SEL_TAG+0, 50); push(SEL_RDY+0, 1);
          push(SEL_TAG+1, 33); push(SEL_RDY+1, 1);
          push(SEL_TAG+2, 2);  push(SEL_RDY+2, 1);
          push(SEL_ID, 0);     push(SEL_FULL, 0);
        end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = observe(e.sel); n_cmp++;
        if (got !== e.exp) begin
          n_err++;
          $display("FAIL test_recover_arch ph%0d %s: got %0d expected %0d", ph, sel_name(e.sel), got, e.exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    test_reset();
    test_forward();
    test_cdb_bypass();
    test_ckpt_recover();
    test_full();
    test_reset_mid_alloc();
    test_recover_arch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end
endmodule
